trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 132 +++++++++++++
 tb/tb_trap_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: detects masked status flags, sequences the entry/exit strobes and presents a handler vector.
// Latency: trap 1 edge after a flag is sampled in IDLE, trap_req 1 edge later; trap_req holds until handler_ack.
module trap_sequencer #(
    parameter int               WIDTH    = 20,
    parameter logic [WIDTH-1:0] VEC_BASE = 20'h00F00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] status_in,
    input  logic [9:0]       flag_mask,
    input  logic             handler_ack,
    input  logic             handler_done,
    output logic             trap,
    output logic             reg_to_instruction,
    output logic             xorData,
    output logic             trap_req,
    output logic [WIDTH-1:0] trap_vector,
    output logic [3:0]       trap_cause,
    output logic [WIDTH-1:0] saved_status,
    output logic             busy,
    output logic [7:0]       trap_count
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        REQUEST,
        HANDLER,
        RESTORE
    } state_t;

    state_t           state_q;
    logic             trap_q;
    logic             rti_q;
    logic             xor_q;
    logic             req_q;
    logic             busy_q;
    logic [WIDTH-1:0] vector_q;
    logic [3:0]       cause_q;
    logic [WIDTH-1:0] saved_q;
    logic [7:0]       count_q;

    logic [9:0]       pending_d;
    logic [3:0]       cause_d;
    logic [WIDTH-1:0] vector_d;

    assign pending_d = status_in[18:9] & flag_mask;

    // Later iterations overwrite earlier ones, so the highest pending index wins.
    always_comb begin
        cause_d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pending_d[i]) begin
                cause_d = 4'(i);
            end
        end
    end

    assign vector_d = VEC_BASE + WIDTH'(cause_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            trap_q   <= 1'b0;
            rti_q    <= 1'b0;
            xor_q    <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            vector_q <= '0;
            cause_q  <= 4'd0;
            saved_q  <= '0;
            count_q  <= 8'd0;
        end else begin
            rti_q <= 1'b0;
            xor_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pending_d) begin
                        state_q  <= CAPTURE;
                        trap_q   <= 1'b1;
                        rti_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        saved_q  <= status_in;
                        cause_q  <= cause_d;
                        vector_q <= vector_d;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                CAPTURE: begin
                    state_q <= REQUEST;
                    req_q   <= 1'b1;
                end
                REQUEST: begin
                    if (handler_ack) begin
                        state_q <= HANDLER;
                        req_q   <= 1'b0;
                    end
                end
                HANDLER: begin
                    if (handler_done) begin
                        state_q <= RESTORE;
                        xor_q   <= 1'b1;
                    end
                end
                RESTORE: begin
                    state_q <= IDLE;
                    trap_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    trap_q  <= 1'b0;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trap               = trap_q;
    assign reg_to_instruction = rti_q;
    assign xorData            = xor_q;
    assign trap_req           = req_q;
    assign busy               = busy_q;
    assign trap_vector        = vector_q;
    assign trap_cause         = cause_q;
    assign saved_status       = saved_q;
    assign trap_count         = count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; pulse vector order is {trap, reg_to_instruction, xorData, trap_req, busy}.
module tb_trap_sequencer;

    logic        clk;
    logic        reset;
    logic [19:0] status_in;
    logic [9:0]  flag_mask;
    logic        handler_ack;
    logic        handler_done;
    logic        trap;
    logic        reg_to_instruction;
    logic        xorData;
    logic        trap_req;
    logic [19:0] trap_vector;
    logic [3:0]  trap_cause;
    logic [19:0] saved_status;
    logic        busy;
    logic [7:0]  trap_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_count = 0;

    logic [4:0] pulses;
    assign pulses = {trap, reg_to_instruction, xorData, trap_req, busy};

    trap_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .status_in         (status_in),
        .flag_mask         (flag_mask),
        .handler_ack       (handler_ack),
        .handler_done      (handler_done),
        .trap              (trap),
        .reg_to_instruction(reg_to_instruction),
        .xorData           (xorData),
        .trap_req          (trap_req),
        .trap_vector       (trap_vector),
        .trap_cause        (trap_cause),
        .saved_status      (saved_status),
        .busy              (busy),
        .trap_count        (trap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        status_in = 20'hFFFFF;
        flag_mask = 10'h3FF;
        handler_ack = 1'b1;
        handler_done = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_pulses got %b want %b", pulses, 5'b00000);
        end
        n_cmp++;
        if ({saved_status, trap_vector, trap_cause, trap_count} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_regs got saved=%h vec=%h cause=%0d cnt=%0d want all 0",
                     saved_status, trap_vector, trap_cause, trap_count);
        end
        status_in = 20'h0;
        handler_ack = 1'b0;
        handler_done = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL idle_after_reset got %b want %b", pulses, 5'b00000);
        end
        exp_count = 0;
    endtask

    task automatic test_single();
        flag_mask = 10'h3FF;
        status_in = 20'h00200;
        tick();
        exp_count++;
        n_cmp++;
        if (pulses !== 5'b11001) begin
            n_fail++;
            $display("FAIL single_capture got %b want %b", pulses, 5'b11001);
        end
        n_cmp++;
        if ({trap_cause, trap_vector, saved_status} !== {4'd0, 20'h00F00, 20'h00200}) begin
            n_fail++;
            $display("FAIL single_fields got cause=%0d vec=%h saved=%h want 0 00f00 00200",
                     trap_cause, trap_vector, saved_status);
        end
        n_cmp++;
        if (trap_count !== 8'(exp_count)) begin
            n_fail++;
            $display("FAIL single_count got %0d want %0d", trap_count, exp_count);
        end
        status_in = 20'h0;
        tick();
        n_cmp++;
        if (pulses !== 5'b10011) begin
            n_fail++;
            $display("FAIL single_request got %b want %b", pulses, 5'b10011);
        end
        handler_ack = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b10001) begin
            n_fail++;
            $display("FAIL single_handler got %b want %b", pulses, 5'b10001);
        end
        handler_ack = 1'b0;
        handler_done = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b10101) begin
            n_fail++;
            $display("FAIL single_restore got %b want %b", pulses, 5'b10101);
        end
        handler_done = 1'b0;
        tick();
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL single_idle got %b want %b", pulses, 5'b00000);
        end
    endtask

    task automatic test_priority();
        status_in = 20'h41000;
        tick();
        exp_count++;
        n_cmp++;
        if ({trap_cause, trap_vector, saved_status} !== {4'd9, 20'h00F09, 20'h41000}) begin
            n_fail++;
            $display("FAIL prio_fields got cause=%0d vec=%h saved=%h want 9 00f09 41000",
                     trap_cause, trap_vector, saved_status);
        end
        status_in = 20'h00200;
        tick();
        handler_ack = 1'b1;
        handler_done = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b10001) begin
            n_fail++;
            $display("FAIL prio_ack_with_done got %b want %b", pulses, 5'b10001);
        end
        n_cmp++;
        if ({trap_cause, saved_status} !== {4'd9, 20'h41000}) begin
            n_fail++;
            $display("FAIL prio_held got cause=%0d saved=%h want 9 41000", trap_cause, saved_status);
        end
        handler_ack = 1'b0;
        handler_done = 1'b0;
        tick();
        n_cmp++;
        if (pulses !== 5'b10001) begin
            n_fail++;
            $display("FAIL prio_wait_done got %b want %b", pulses, 5'b10001);
        end
        handler_done = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b10101) begin
            n_fail++;
            $display("FAIL prio_restore got %b want %b", pulses, 5'b10101);
        end
        handler_done = 1'b0;
        status_in = 20'h0;
        tick();
    endtask

    task automatic test_ack_delay();
        int xor_pulses;
        status_in = 20'h00800;
        tick();
        exp_count++;
        status_in = 20'h0;
        tick();
        handler_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({pulses, trap_vector, trap_cause} !== {5'b10011, 20'h00F02, 4'd2}) begin
                n_fail++;
                $display("FAIL delay_request[%0d] got %b vec=%h cause=%0d want 10011 00f02 2",
                         i, pulses, trap_vector, trap_cause);
            end
            if (i < 4) tick();
        end
        handler_ack = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b10001) begin
            n_fail++;
            $display("FAIL delay_handler got %b want %b", pulses, 5'b10001);
        end
        handler_ack = 1'b0;
        tick();
        handler_done = 1'b0;
        xor_pulses = int'(xorData);
        for (int i = 0; i < 4; i++) begin
            tick();
            xor_pulses += int'(xorData);
        end
        n_cmp++;
        if (xor_pulses !== 1) begin
            n_fail++;
            $display("FAIL delay_xor_pulses got %0d want 1", xor_pulses);
        end
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL delay_idle got %b want %b", pulses, 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        status_in = 20'h00200;
        tick();
        tick();
        handler_ack = 1'b1;
        tick();
        handler_ack = 1'b0;
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        tick();
        exp_count++;
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL b2b_gap got %b want %b", pulses, 5'b00000);
        end
        tick();
        exp_count++;
        n_cmp++;
        if ({pulses, trap_count} !== {5'b11001, 8'(exp_count)}) begin
            n_fail++;
            $display("FAIL b2b_second got %b cnt=%0d want 11001 cnt=%0d", pulses, trap_count, exp_count);
        end
        status_in = 20'h0;
        tick();
        handler_ack = 1'b1;
        tick();
        handler_ack = 1'b0;
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_handler();
        int xor_seen;
        status_in = 20'h00400;
        tick();
        status_in = 20'h0;
        tick();
        handler_ack = 1'b1;
        tick();
        handler_ack = 1'b0;
        reset = 1'b1;
        handler_done = 1'b1;
        tick();
        n_cmp++;
        if (pulses !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid_pulses got %b want %b", pulses, 5'b00000);
        end
        n_cmp++;
        if ({saved_status, trap_vector, trap_cause, trap_count} !== 52'h0) begin
            n_fail++;
            $display("FAIL rst_mid_regs got saved=%h vec=%h cause=%0d cnt=%0d want all 0",
                     saved_status, trap_vector, trap_cause, trap_count);
        end
        reset = 1'b0;
        xor_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            xor_seen += int'(xorData) + int'(busy);
        end
        handler_done = 1'b0;
        n_cmp++;
        if (xor_seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_restore got %0d active cycles want 0", xor_seen);
        end
        exp_count = 0;
    endtask

    task automatic run_trap();
        bit got_req;
        got_req = 1'b0;
        status_in = 20'h00200;
        for (int i = 0; i < 8 && !got_req; i++) begin
            tick();
            got_req = trap_req;
        end
        if (!got_req) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_trap_timeout got trap_req=0 want 1 within 8 cycles");
        end
        status_in = 20'h0;
        handler_ack = 1'b1;
        tick();
        handler_ack = 1'b0;
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        int active;
        flag_mask = 10'h3FF;
        for (int i = 0; i < 255; i++) run_trap();
        n_cmp++;
        if (trap_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_255 got %0d want 255", trap_count);
        end
        run_trap();
        n_cmp++;
        if (trap_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_256 got %0d want 255", trap_count);
        end
        run_trap();
        n_cmp++;
        if (trap_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold got %0d want 255", trap_count);
        end
        flag_mask = 10'h000;
        status_in = 20'hFFFFF;
        active = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            active += int'(busy) + int'(trap);
        end
        n_cmp++;
        if (active !== 0) begin
            n_fail++;
            $display("FAIL mask_zero got %0d active cycles want 0", active);
        end
        status_in = 20'h0;
    endtask

    initial begin
        reset = 1'b1;
        status_in = 20'h0;
        flag_mask = 10'h0;
        handler_ack = 1'b0;
        handler_done = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_ack_delay();
        test_back_to_back();
        test_reset_handler();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
